// File: rtl/mipi_tx_payload_framer_if.sv
// Framer bus: payload source handshake on one side and MIPI TX video
// signals on the other. The framer takes the master modport and the
// source/sink side takes the slave modport.
interface mipi_tx_payload_framer_if #(
   parameter int DLEN = 18
);
   logic [DLEN*8-1:0] pix_gen_data;
   logic              data_available;
   logic              busy;
   logic              frame_done;
   logic [15:0]       frames_sent;
   logic              mipi_tx_VALID;
   logic              mipi_tx_HSYNC;
   logic              mipi_tx_VSYNC;
   logic [63:0]       mipi_tx_DATA;
   logic [5:0]        mipi_tx_TYPE;
   logic [15:0]       mipi_tx_HRES;

   modport master (
      input  pix_gen_data, data_available,
      output busy, frame_done, frames_sent,
      output mipi_tx_VALID, mipi_tx_HSYNC, mipi_tx_VSYNC,
      output mipi_tx_DATA, mipi_tx_TYPE, mipi_tx_HRES
   );

   modport slave (
      output pix_gen_data, data_available,
      input  busy, frame_done, frames_sent,
      input  mipi_tx_VALID, mipi_tx_HSYNC, mipi_tx_VSYNC,
      input  mipi_tx_DATA, mipi_tx_TYPE, mipi_tx_HRES
   );
endinterface

// File: rtl/mipi_tx_payload_framer.sv
// MIPI TX payload framer: latches one DLEN-byte payload, appends an XOR
// checksum byte and sends it on every line of one complete video frame
// (VSYNC, porches, HSYNC, 64-bit VALID beats). All outputs are registered
// from the next-state decode so they line up with the state they describe.
module mipi_tx_payload_framer #(
   parameter int          DLEN      = 18,
   parameter int          NLINES    = 2,
   parameter int          VS_CYC    = 4,
   parameter int          HS_CYC    = 4,
   parameter int          BLANK_CYC = 8,
   parameter logic [5:0]  DTYPE     = 6'h24
) (
   input  logic                       tx_pixel_clk,
   input  logic                       rst_n,
   mipi_tx_payload_framer_if.master   bus
);

   localparam int NWORDS = (DLEN + 1 + 7) / 8;
   localparam int M1     = (VS_CYC > HS_CYC) ? VS_CYC : HS_CYC;
   localparam int M2     = (M1 > BLANK_CYC) ? M1 : BLANK_CYC;
   localparam int MAXD   = (M2 > NWORDS) ? M2 : NWORDS;
   localparam int CW     = ($clog2(MAXD) < 1) ? 1 : $clog2(MAXD);
   localparam int LW     = ($clog2(NLINES) < 1) ? 1 : $clog2(NLINES);

   typedef enum logic [3:0] {
      IDLE, VS, VBP, HS, HBP, DATA, HFP, VFP, DONE
   } state_t;

   state_t                state, state_nx;
   logic [CW-1:0]         cnt, cnt_nx, dur;
   logic [LW-1:0]         line, line_nx;
   logic [DLEN*8-1:0]     payload;
   logic [7:0]            chk, chk_in;
   logic [NWORDS*64-1:0]  stream;
   logic [15:0]           sent_cnt;

   assign bus.mipi_tx_TYPE = DTYPE;
   assign bus.mipi_tx_HRES = 16'(NWORDS);
   assign bus.frames_sent  = sent_cnt;

   // Checksum of the incoming payload, captured together with it on accept.
   always_comb begin
      chk_in = '0;
      for (int i = 0; i < DLEN; i++) chk_in ^= bus.pix_gen_data[8*i +: 8];
   end

   // Byte stream for one line: payload, checksum, then zero padding.
   always_comb begin
      stream = '0;
      stream[DLEN*8-1:0] = payload;
      stream[DLEN*8 +: 8] = chk;
   end

   // Length (minus one) of the current timed state.
   always_comb begin
      case (state)
         VS:      dur = CW'(VS_CYC - 1);
         HS:      dur = CW'(HS_CYC - 1);
         DATA:    dur = CW'(NWORDS - 1);
         default: dur = CW'(BLANK_CYC - 1);
      endcase
   end

   // Next-state logic: each timed state runs dur+1 cycles, lines repeat.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CW'(1);
      line_nx  = line;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (bus.data_available) state_nx = VS;
         end
         DONE: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            if (cnt == dur) begin
               cnt_nx = '0;
               case (state)
                  VS:   state_nx = VBP;
                  VBP:  begin state_nx = HS; line_nx = '0; end
                  HS:   state_nx = HBP;
                  HBP:  state_nx = DATA;
                  DATA: state_nx = HFP;
                  HFP: begin
                     if (line == LW'(NLINES - 1)) state_nx = VFP;
                     else begin
                        state_nx = HS;
                        line_nx  = line + LW'(1);
                     end
                  end
                  VFP:     state_nx = DONE;
                  default: state_nx = IDLE;
               endcase
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge tx_pixel_clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         line  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         line  <= line_nx;
      end
   end

   // Payload latch and registered outputs decoded from the next state.
   always_ff @(posedge tx_pixel_clk) begin
      if (!rst_n) begin
         payload           <= '0;
         chk               <= '0;
         sent_cnt          <= '0;
         bus.busy          <= 1'b0;
         bus.frame_done    <= 1'b0;
         bus.mipi_tx_VSYNC <= 1'b0;
         bus.mipi_tx_HSYNC <= 1'b0;
         bus.mipi_tx_VALID <= 1'b0;
         bus.mipi_tx_DATA  <= '0;
      end else begin
         if (state == IDLE && bus.data_available) begin
            payload <= bus.pix_gen_data;
            chk     <= chk_in;
         end
         if (state_nx == DONE) sent_cnt <= sent_cnt + 16'd1;
         bus.busy          <= (state_nx != IDLE);
         bus.frame_done    <= (state_nx == DONE);
         bus.mipi_tx_VSYNC <= (state_nx == VS);
         bus.mipi_tx_HSYNC <= (state_nx == HS);
         bus.mipi_tx_VALID <= (state_nx == DATA);
         bus.mipi_tx_DATA  <= (state_nx == DATA) ? stream[64*int'(cnt_nx) +: 64] : '0;
      end
   end

endmodule

// File: tb/tb_mipi_tx_payload_framer.sv
// Directed bench for mipi_tx_payload_framer: default build plus a DLEN=16
// build, with hand-computed frame timing and beat contents.
module tb_mipi_tx_payload_framer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mipi_tx_payload_framer_if #(.DLEN(18)) bus ();
   mipi_tx_payload_framer_if #(.DLEN(16)) bus2 ();

   mipi_tx_payload_framer dut (.tx_pixel_clk(clk), .rst_n(rst_n), .bus(bus));
   mipi_tx_payload_framer #(.DLEN(16)) dut2 (.tx_pixel_clk(clk), .rst_n(rst_n), .bus(bus2));

   int n_cmp = 0;
   int n_bad = 0;

   logic [143:0] pay_a, pay_b, pay_alt;
   logic [63:0]  exp_a [3] = '{64'h0807060504030201, 64'h100F0E0D0C0B0A09, 64'h0000000000131211};
   logic [63:0]  exp_b [3] = '{64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5, 64'h000000000000A5A5};
   logic [63:0]  exp_f [3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000};

   int c_busy, c_done, c_vs, c_hs, c_excl, c_dz, done_at, first_hs, first_val, vs0;
   logic [63:0] beats [$];

   // Sample bus for ncyc negedges; at cycle inj push a second request.
   task automatic capture(input int ncyc, input int inj);
      c_busy = 0; c_done = 0; c_vs = 0; c_hs = 0; c_excl = 0; c_dz = 0;
      done_at = -1; first_hs = -1; first_val = -1; vs0 = 0;
      beats.delete();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (c == inj) begin
            bus.pix_gen_data = pay_alt;
            bus.data_available = 1'b1;
         end
         if (inj >= 0 && c == inj + 1) bus.data_available = 1'b0;
         if (c == 0) vs0 = int'(bus.mipi_tx_VSYNC);
         if (bus.busy) c_busy++;
         if (bus.frame_done) begin c_done++; done_at = c; end
         if (bus.mipi_tx_VSYNC) c_vs++;
         if (bus.mipi_tx_HSYNC) begin c_hs++; if (first_hs < 0) first_hs = c; end
         if (int'(bus.mipi_tx_VSYNC) + int'(bus.mipi_tx_HSYNC) + int'(bus.mipi_tx_VALID) > 1) c_excl++;
         if (!bus.mipi_tx_VALID && bus.mipi_tx_DATA != 64'h0) c_dz++;
         if (bus.mipi_tx_VALID) begin
            beats.push_back(bus.mipi_tx_DATA);
            if (first_val < 0) first_val = c;
         end
      end
   endtask

   task automatic strobe();
      bus.data_available = 1'b1;
      @(posedge clk); #1;
      bus.data_available = 1'b0;
   endtask

   task automatic test_reset();
      int viol;
      rst_n = 1'b0;
      bus.data_available = 1'b0; bus.pix_gen_data = '0;
      bus2.data_available = 1'b0; bus2.pix_gen_data = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      viol = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.busy || bus.frame_done || bus.mipi_tx_VSYNC || bus.mipi_tx_HSYNC ||
             bus.mipi_tx_VALID || bus.mipi_tx_DATA != 0 || bus.frames_sent != 0) viol++;
      end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL reset_outputs_zero got %0d nonzero cycles want 0", viol); end
      n_cmp++; if (bus.mipi_tx_TYPE !== 6'h24) begin n_bad++; $display("FAIL reset_type got %h want 24", bus.mipi_tx_TYPE); end
      n_cmp++; if (bus.mipi_tx_HRES !== 16'd3) begin n_bad++; $display("FAIL reset_hres got %0d want 3", bus.mipi_tx_HRES); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_cmp++; if (bus.frames_sent !== 16'd0) begin n_bad++; $display("FAIL reset_frames_sent got %0d want 0", bus.frames_sent); end
   endtask

   task automatic test_frame();
      bus.pix_gen_data = pay_a;
      strobe();
      capture(75, -1);
      n_cmp++; if (vs0 !== 1) begin n_bad++; $display("FAIL frame_vs_first got %0d want 1", vs0); end
      n_cmp++; if (c_vs !== 4) begin n_bad++; $display("FAIL frame_vs_len got %0d want 4", c_vs); end
      n_cmp++; if (c_hs !== 8) begin n_bad++; $display("FAIL frame_hs_total got %0d want 8", c_hs); end
      n_cmp++; if (first_hs !== 12) begin n_bad++; $display("FAIL frame_hs_start got %0d want 12", first_hs); end
      n_cmp++; if (first_val !== 24) begin n_bad++; $display("FAIL frame_valid_start got %0d want 24", first_val); end
      n_cmp++; if (c_busy !== 67) begin n_bad++; $display("FAIL frame_busy_len got %0d want 67", c_busy); end
      n_cmp++; if (c_done !== 1 || done_at !== 66) begin n_bad++; $display("FAIL frame_done got %0d at %0d want 1 at 66", c_done, done_at); end
      n_cmp++; if (beats.size() !== 6) begin n_bad++; $display("FAIL frame_beat_count got %0d want 6", beats.size()); end
      for (int i = 0; i < beats.size(); i++) begin
         n_cmp++; if (beats[i] !== exp_a[i%3]) begin n_bad++; $display("FAIL frame_beat%0d got %h want %h", i, beats[i], exp_a[i%3]); end
      end
      n_cmp++; if (c_excl !== 0 || c_dz !== 0) begin n_bad++; $display("FAIL frame_excl_dz got %0d/%0d want 0/0", c_excl, c_dz); end
      n_cmp++; if (bus.frames_sent !== 16'd1) begin n_bad++; $display("FAIL frame_count got %0d want 1", bus.frames_sent); end
   endtask

   task automatic test_back_to_back();
      bus.pix_gen_data = pay_a;
      bus.data_available = 1'b1;
      @(posedge clk); #1;
      capture(135, -1);
      bus.data_available = 1'b0;
      n_cmp++; if (c_done !== 2 || done_at !== 134) begin n_bad++; $display("FAIL b2b_done got %0d last %0d want 2 last 134", c_done, done_at); end
      n_cmp++; if (c_busy !== 134) begin n_bad++; $display("FAIL b2b_busy got %0d want 134", c_busy); end
      n_cmp++; if (beats.size() !== 12) begin n_bad++; $display("FAIL b2b_beats got %0d want 12", beats.size()); end
      n_cmp++; if (bus.frames_sent !== 16'd3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", bus.frames_sent); end
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_ignore();
      bus.pix_gen_data = pay_a;
      strobe();
      capture(90, 10);
      bus.pix_gen_data = pay_a;
      n_cmp++; if (c_done !== 1) begin n_bad++; $display("FAIL ign_done got %0d want 1", c_done); end
      n_cmp++; if (c_busy !== 67) begin n_bad++; $display("FAIL ign_busy got %0d want 67", c_busy); end
      n_cmp++; if (beats.size() !== 6) begin n_bad++; $display("FAIL ign_beats got %0d want 6", beats.size()); end
      for (int i = 0; i < beats.size(); i++) begin
         n_cmp++; if (beats[i] !== exp_a[i%3]) begin n_bad++; $display("FAIL ign_beat%0d got %h want %h", i, beats[i], exp_a[i%3]); end
      end
      n_cmp++; if (bus.frames_sent !== 16'd4) begin n_bad++; $display("FAIL ign_count got %0d want 4", bus.frames_sent); end
   endtask

   task automatic test_reset_mid();
      bus.pix_gen_data = pay_a;
      strobe();
      repeat (48) @(negedge clk);
      n_cmp++; if (bus.mipi_tx_VALID !== 1'b1) begin n_bad++; $display("FAIL rmid_in_data got %b want 1", bus.mipi_tx_VALID); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if (bus.busy || bus.frame_done || bus.mipi_tx_VSYNC || bus.mipi_tx_HSYNC || bus.mipi_tx_VALID ||
          bus.mipi_tx_DATA != 0 || bus.frames_sent != 0) begin
         n_bad++; $display("FAIL rmid_outputs got busy=%b done=%b valid=%b data=%h cnt=%0d want all 0",
                           bus.busy, bus.frame_done, bus.mipi_tx_VALID, bus.mipi_tx_DATA, bus.frames_sent);
      end
      capture(30, -1);
      n_cmp++; if (c_done !== 0 || c_busy !== 0) begin n_bad++; $display("FAIL rmid_quiet got done=%0d busy=%0d want 0/0", c_done, c_busy); end
      bus.pix_gen_data = pay_b;
      strobe();
      capture(70, -1);
      n_cmp++; if (c_done !== 1 || beats.size() !== 6) begin n_bad++; $display("FAIL rmid_refrm got done=%0d beats=%0d want 1/6", c_done, beats.size()); end
      for (int i = 0; i < beats.size(); i++) begin
         n_cmp++; if (beats[i] !== exp_b[i%3]) begin n_bad++; $display("FAIL rmid_beat%0d got %h want %h", i, beats[i], exp_b[i%3]); end
      end
      n_cmp++; if (bus.frames_sent !== 16'd1) begin n_bad++; $display("FAIL rmid_count got %0d want 1", bus.frames_sent); end
   endtask

   task automatic test_dlen16_wrap();
      logic [63:0] b2 [$];
      int done2;
      n_cmp++; if (bus2.mipi_tx_HRES !== 16'd3) begin n_bad++; $display("FAIL d16_hres got %0d want 3", bus2.mipi_tx_HRES); end
      bus2.pix_gen_data = '1;
      force dut2.sent_cnt = 16'hFFFF;
      @(negedge clk);
      release dut2.sent_cnt;
      @(negedge clk);
      n_cmp++; if (bus2.frames_sent !== 16'hFFFF) begin n_bad++; $display("FAIL d16_preset got %h want ffff", bus2.frames_sent); end
      bus2.data_available = 1'b1;
      @(posedge clk); #1;
      bus2.data_available = 1'b0;
      done2 = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (bus2.mipi_tx_VALID) b2.push_back(bus2.mipi_tx_DATA);
         if (bus2.frame_done) done2++;
      end
      n_cmp++; if (done2 !== 1 || b2.size() !== 6) begin n_bad++; $display("FAIL d16_frame got done=%0d beats=%0d want 1/6", done2, b2.size()); end
      for (int i = 0; i < b2.size(); i++) begin
         n_cmp++; if (b2[i] !== exp_f[i%3]) begin n_bad++; $display("FAIL d16_beat%0d got %h want %h", i, b2[i], exp_f[i%3]); end
      end
      n_cmp++; if (bus2.frames_sent !== 16'h0000) begin n_bad++; $display("FAIL d16_wrap got %h want 0000", bus2.frames_sent); end
   endtask

   initial begin
      for (int i = 0; i < 18; i++) begin
         pay_a[8*i +: 8]   = 8'(i + 1);
         pay_b[8*i +: 8]   = 8'hA5;
         pay_alt[8*i +: 8] = 8'hC3;
      end
      test_reset();
      test_frame();
      repeat (2) @(negedge clk);
      test_back_to_back();
      test_ignore();
      repeat (2) @(negedge clk);
      test_reset_mid();
      repeat (2) @(negedge clk);
      test_dlen16_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
